// File: rtl/ahb_bus_arbiter_if.sv
// ahb_bus_arbiter_if: request/lock inputs, muxed AHB control and grant outputs of the bus arbiter
interface ahb_bus_arbiter_if;
  logic hbusreq_1, hbusreq_2, hbusreq_3, hbusreq_4;
  logic hlock_1, hlock_2, hlock_3, hlock_4;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic hready;
  logic [1:0] hresp;
  logic [3:0] hsplit;
  logic hgrant_1, hgrant_2, hgrant_3, hgrant_4;
  logic [1:0] hmaster;
  logic hmastlock;
  modport master (
    output hbusreq_1, hbusreq_2, hbusreq_3, hbusreq_4,
    output hlock_1, hlock_2, hlock_3, hlock_4,
    output htrans, hburst, hready, hresp, hsplit,
    input hgrant_1, hgrant_2, hgrant_3, hgrant_4, hmaster, hmastlock
  );
  modport slave (
    input hbusreq_1, hbusreq_2, hbusreq_3, hbusreq_4,
    input hlock_1, hlock_2, hlock_3, hlock_4,
    input htrans, hburst, hready, hresp, hsplit,
    output hgrant_1, hgrant_2, hgrant_3, hgrant_4, hmaster, hmastlock
  );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: 4-master round-robin AHB arbiter with fixed-burst/lock hold and split masking
module ahb_bus_arbiter #(
  parameter logic [1:0] DEFAULT_MASTER = 2'd0
) (
  input logic hclk,
  input logic hreset,
  ahb_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {ST_DEFAULT, ST_GRANTED, ST_BURST, ST_LOCKED} state_t;
  state_t state, state_nxt;
  logic [1:0] gidx, gidx_nxt, ptr, ptr_nxt, pick, mst;
  logic [3:0] req, lock, mask, mask_nxt, elig, cnt, cnt_nxt, grant, len_m1;
  logic found, rearb, split_ev, retry_ev, burst_start, incr_hold, mlock;
  assign req = {bus.hbusreq_4, bus.hbusreq_3, bus.hbusreq_2, bus.hbusreq_1};
  assign lock = {bus.hlock_4, bus.hlock_3, bus.hlock_2, bus.hlock_1};
  assign split_ev = bus.hready && bus.hresp == 2'b11;
  assign retry_ev = bus.hready && bus.hresp == 2'b10;
  // a resume strobe beats a split landing on the same master in the same cycle
  assign mask_nxt = (mask | (split_ev ? 4'b0001 << mst : 4'b0000)) & ~bus.hsplit;
  assign elig = req & ~mask_nxt;
  assign len_m1 = bus.hburst[2:1] == 2'b01 ? 4'd3 : bus.hburst[2:1] == 2'b10 ? 4'd7 : 4'd15;
  assign burst_start = bus.htrans == 2'b10 && bus.hburst[2:1] != 2'b00 && bus.hready;
  assign incr_hold = bus.hburst == 3'b001 && bus.htrans != 2'b00 && req[gidx];
  assign found = |elig;
  assign {bus.hgrant_4, bus.hgrant_3, bus.hgrant_2, bus.hgrant_1} = grant;
  assign bus.hmaster = mst;
  assign bus.hmastlock = mlock;
  // scan from farthest to nearest so the master right after ptr wins
  always_comb begin
    pick = DEFAULT_MASTER;
    for (int i = 4; i >= 1; i--)
      if (elig[ptr + 2'(i)]) pick = ptr + 2'(i);
  end
  always_comb begin
    state_nxt = state;
    gidx_nxt = gidx;
    ptr_nxt = ptr;
    cnt_nxt = cnt;
    rearb = 1'b0;
    case (state)
      ST_DEFAULT: rearb = 1'b1;
      ST_GRANTED:
        if (split_ev || !(lock[gidx] || burst_start || incr_hold)) rearb = 1'b1;
        else if (lock[gidx]) state_nxt = ST_LOCKED;
        else if (burst_start) begin
          state_nxt = ST_BURST;
          cnt_nxt = len_m1;
        end
      ST_BURST:
        if (split_ev || retry_ev || (cnt == 4'd1 && bus.hready)) rearb = 1'b1;
        else if (bus.htrans == 2'b11 && bus.hready) cnt_nxt = cnt - 4'd1;
      ST_LOCKED:
        if (split_ev) rearb = 1'b1;
        else if (!lock[gidx] && bus.hready && !bus.htrans[0]) state_nxt = ST_GRANTED;
    endcase
    if (rearb) begin
      gidx_nxt = found ? pick : DEFAULT_MASTER;
      ptr_nxt = found ? pick : ptr;
      state_nxt = found ? ST_GRANTED : ST_DEFAULT;
      cnt_nxt = 4'd0;
    end
  end
  always_ff @(posedge hclk or posedge hreset)
    if (hreset) begin
      state <= ST_DEFAULT;
      gidx <= DEFAULT_MASTER;
      grant <= 4'b0001 << DEFAULT_MASTER;
      ptr <= DEFAULT_MASTER;
      mask <= 4'b0000;
      cnt <= 4'd0;
      mst <= DEFAULT_MASTER;
      mlock <= 1'b0;
    end else begin
      state <= state_nxt;
      gidx <= gidx_nxt;
      grant <= 4'b0001 << gidx_nxt;
      ptr <= ptr_nxt;
      mask <= mask_nxt;
      cnt <= cnt_nxt;
      if (bus.hready) begin
        mst <= gidx;
        mlock <= lock[gidx];
      end
    end
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb_ahb_bus_arbiter: directed vector table plus a reset-mid-burst sequence
module tb_ahb_bus_arbiter;
  logic hclk = 1'b0;
  logic hreset = 1'b1;
  ahb_bus_arbiter_if bus();
  ahb_bus_arbiter #(.DEFAULT_MASTER(2'd0)) dut (.hclk(hclk), .hreset(hreset), .bus(bus));
  always #5 hclk = ~hclk;
  localparam logic [1:0] I = 2'b00, B = 2'b01, N = 2'b10, S = 2'b11;
  localparam logic [2:0] SG = 3'b000, B8 = 3'b101, B16 = 3'b111;
  typedef struct {
    logic [3:0] req, lock;
    logic [1:0] trans;
    logic [2:0] burst;
    logic rdy;
    logic [1:0] resp;
    logic [3:0] split, gnt;
    logic [1:0] mst;
    logic mlock;
  } vec_t;
  vec_t v[$];
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask
  task automatic drive(input logic [3:0] req, input logic [3:0] lock, input logic [1:0] trans,
                       input logic [2:0] burst, input logic rdy, input logic [1:0] resp,
                       input logic [3:0] split);
    {bus.hbusreq_4, bus.hbusreq_3, bus.hbusreq_2, bus.hbusreq_1} = req;
    {bus.hlock_4, bus.hlock_3, bus.hlock_2, bus.hlock_1} = lock;
    bus.htrans = trans;
    bus.hburst = burst;
    bus.hready = rdy;
    bus.hresp = resp;
    bus.hsplit = split;
  endtask
  task automatic chk_out(input string tag, input logic [3:0] gnt, input logic [1:0] mst,
                         input logic mlock);
    logic [3:0] g;
    g = {bus.hgrant_4, bus.hgrant_3, bus.hgrant_2, bus.hgrant_1};
    chk({tag, " grant"}, g, gnt);
    chk({tag, " hmaster"}, {2'b00, bus.hmaster}, {2'b00, mst});
    chk({tag, " hmastlock"}, {3'b000, bus.hmastlock}, {3'b000, mlock});
    chk({tag, " onehot"}, {3'b000, $onehot(g)}, 4'b0001);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    // round robin with SINGLE transfers, then idle bus
    v.push_back('{4'b1111, 4'b0000, I, SG, 1'b1, 2'b00, 4'b0000, 4'b0010, 2'd0, 1'b0});
    v.push_back('{4'b1111, 4'b0000, I, SG, 1'b1, 2'b00, 4'b0000, 4'b0100, 2'd1, 1'b0});
    v.push_back('{4'b1111, 4'b0000, I, SG, 1'b1, 2'b00, 4'b0000, 4'b1000, 2'd2, 1'b0});
    v.push_back('{4'b1111, 4'b0000, I, SG, 1'b1, 2'b00, 4'b0000, 4'b0001, 2'd3, 1'b0});
    v.push_back('{4'b1111, 4'b0000, I, SG, 1'b1, 2'b00, 4'b0000, 4'b0010, 2'd0, 1'b0});
    v.push_back('{4'b0000, 4'b0000, I, SG, 1'b1, 2'b00, 4'b0000, 4'b0001, 2'd1, 1'b0});
    v.push_back('{4'b0000, 4'b0000, I, SG, 1'b1, 2'b00, 4'b0000, 4'b0001, 2'd0, 1'b0});
    // master 2 INCR8 with master 3 waiting, including stalls and a BUSY beat
    v.push_back('{4'b0010, 4'b0000, I, SG, 1'b1, 2'b00, 4'b0000, 4'b0010, 2'd0, 1'b0});
    v.push_back('{4'b0110, 4'b0000, N, B8, 1'b1, 2'b00, 4'b0000, 4'b0010, 2'd1, 1'b0});
    v.push_back('{4'b0110, 4'b0000, S, B8, 1'b1, 2'b00, 4'b0000, 4'b0010, 2'd1, 1'b0});
    v.push_back('{4'b0110, 4'b0000, S, B8, 1'b0, 2'b00, 4'b0000, 4'b0010, 2'd1, 1'b0});
    v.push_back('{4'b0110, 4'b0000, S, B8, 1'b1, 2'b00, 4'b0000, 4'b0010, 2'd1, 1'b0});
    v.push_back('{4'b0110, 4'b0000, B, B8, 1'b1, 2'b00, 4'b0000, 4'b0010, 2'd1, 1'b0});
    v.push_back('{4'b0110, 4'b0000, S, B8, 1'b1, 2'b00, 4'b0000, 4'b0010, 2'd1, 1'b0});
    v.push_back('{4'b0110, 4'b0000, S, B8, 1'b1, 2'b00, 4'b0000, 4'b0010, 2'd1, 1'b0});
    v.push_back('{4'b0110, 4'b0000, S, B8, 1'b1, 2'b00, 4'b0000, 4'b0010, 2'd1, 1'b0});
    v.push_back('{4'b0110, 4'b0000, S, B8, 1'b1, 2'b00, 4'b0000, 4'b0010, 2'd1, 1'b0});
    v.push_back('{4'b0110, 4'b0000, S, B8, 1'b0, 2'b00, 4'b0000, 4'b0010, 2'd1, 1'b0});
    v.push_back('{4'b0110, 4'b0000, S, B8, 1'b1, 2'b00, 4'b0000, 4'b0100, 2'd1, 1'b0});
    v.push_back('{4'b0100, 4'b0000, I, SG, 1'b1, 2'b00, 4'b0000, 4'b0100, 2'd2, 1'b0});
    // master 1 locked over three transfers, others requesting
    v.push_back('{4'b0001, 4'b0001, I, SG, 1'b1, 2'b00, 4'b0000, 4'b0001, 2'd2, 1'b0});
    v.push_back('{4'b1111, 4'b0001, N, SG, 1'b1, 2'b00, 4'b0000, 4'b0001, 2'd0, 1'b1});
    v.push_back('{4'b1111, 4'b0001, N, SG, 1'b1, 2'b00, 4'b0000, 4'b0001, 2'd0, 1'b1});
    v.push_back('{4'b1111, 4'b0001, N, SG, 1'b0, 2'b00, 4'b0000, 4'b0001, 2'd0, 1'b1});
    v.push_back('{4'b1111, 4'b0001, N, SG, 1'b1, 2'b00, 4'b0000, 4'b0001, 2'd0, 1'b1});
    v.push_back('{4'b1111, 4'b0000, I, SG, 1'b1, 2'b00, 4'b0000, 4'b0001, 2'd0, 1'b0});
    v.push_back('{4'b1111, 4'b0000, I, SG, 1'b1, 2'b00, 4'b0000, 4'b0010, 2'd0, 1'b0});
    // master 3 split, masked out, then resumed by hsplit
    v.push_back('{4'b0100, 4'b0000, I, SG, 1'b1, 2'b00, 4'b0000, 4'b0100, 2'd1, 1'b0});
    v.push_back('{4'b0100, 4'b0000, I, SG, 1'b1, 2'b00, 4'b0000, 4'b0100, 2'd2, 1'b0});
    v.push_back('{4'b0100, 4'b0000, I, SG, 1'b0, 2'b11, 4'b0000, 4'b0100, 2'd2, 1'b0});
    v.push_back('{4'b0110, 4'b0000, I, SG, 1'b1, 2'b11, 4'b0000, 4'b0010, 2'd2, 1'b0});
    v.push_back('{4'b0110, 4'b0000, I, SG, 1'b1, 2'b00, 4'b0000, 4'b0010, 2'd1, 1'b0});
    v.push_back('{4'b0100, 4'b0000, I, SG, 1'b1, 2'b00, 4'b0000, 4'b0001, 2'd1, 1'b0});
    v.push_back('{4'b0110, 4'b0000, I, SG, 1'b1, 2'b00, 4'b0100, 4'b0100, 2'd0, 1'b0});
    v.push_back('{4'b0000, 4'b0000, I, SG, 1'b1, 2'b00, 4'b0000, 4'b0001, 2'd2, 1'b0});
    // split and resume of the same master in one cycle: resume wins
    v.push_back('{4'b0001, 4'b0000, I, SG, 1'b1, 2'b11, 4'b0100, 4'b0001, 2'd0, 1'b0});
    v.push_back('{4'b0100, 4'b0000, I, SG, 1'b1, 2'b00, 4'b0000, 4'b0100, 2'd0, 1'b0});
    // mask master 3 again, then master 2 starts INCR16 with master 1 waiting
    v.push_back('{4'b0100, 4'b0000, I, SG, 1'b1, 2'b00, 4'b0000, 4'b0100, 2'd2, 1'b0});
    v.push_back('{4'b0110, 4'b0000, I, SG, 1'b1, 2'b11, 4'b0000, 4'b0010, 2'd2, 1'b0});
    v.push_back('{4'b0111, 4'b0000, N, B16, 1'b1, 2'b00, 4'b0000, 4'b0010, 2'd1, 1'b0});
    v.push_back('{4'b0111, 4'b0000, S, B16, 1'b1, 2'b00, 4'b0000, 4'b0010, 2'd1, 1'b0});
    v.push_back('{4'b0111, 4'b0000, S, B16, 1'b1, 2'b01, 4'b0000, 4'b0010, 2'd1, 1'b0});
    drive(4'b0000, 4'b0000, I, SG, 1'b1, 2'b00, 4'b0000);
    repeat (2) @(posedge hclk);
    #1;
    chk_out("reset", 4'b0001, 2'd0, 1'b0);
    hreset = 1'b0;
    foreach (v[i]) begin
      drive(v[i].req, v[i].lock, v[i].trans, v[i].burst, v[i].rdy, v[i].resp, v[i].split);
      @(posedge hclk);
      #1;
      chk_out($sformatf("v%0d", i + 1), v[i].gnt, v[i].mst, v[i].mlock);
    end
    // asynchronous reset in the middle of the INCR16 hold
    #2 hreset = 1'b1;
    #1 chk_out("async reset", 4'b0001, 2'd0, 1'b0);
    drive(4'b0100, 4'b0000, I, SG, 1'b1, 2'b00, 4'b0000);
    @(posedge hclk);
    #1;
    chk_out("reset held", 4'b0001, 2'd0, 1'b0);
    hreset = 1'b0;
    @(posedge hclk);
    #1;
    chk_out("after reset", 4'b0100, 2'd0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ahb_bus_arbiter.md
AHB_BUS_ARBITER -- requirements
Module: ahb_bus_arbiter

Interface
REQ-001 SHALL provide parameter: DEFAULT_MASTER, 0, 2-bit index of the master granted when no request is pending (0 = master 1).
REQ-002 SHALL provide ports:
- hclk  in  1  bus clock; all state on rising edge.
- hreset  in  1  asynchronous, active-high reset.
- hbusreq_1..hbusreq_4  in  1 each  bus request per master.
- hlock_1..hlock_4  in  1 each  locked-transfer request per master.
- htrans  in  2  muxed bus transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- hburst  in  3  muxed burst type: SINGLE=000, INCR=001, WRAP4=010, INCR4=011, WRAP8=100, INCR8=101, WRAP16=110, INCR16=111.
- hready  in  1  muxed slave ready.
- hresp  in  2  muxed response: OKAY=00, ERROR=01, RETRY=10, SPLIT=11.
- hsplit  in  4  split-resume strobes; bit n releases master n+1.
- hgrant_1..hgrant_4  out  1 each  one-hot grant, registered.
- hmaster  out  2  index of the address-phase owner, registered.
- hmastlock  out  1  current transfer is locked, registered.

Function
REQ-003 SHALL keep hgrant_1..4 one-hot at all times.
REQ-004 SHALL use round-robin priority: search starts at the master after the last granted index and wraps 4->1.
REQ-005 SHALL exclude from arbitration any master whose split-mask bit is set.
REQ-006 SHALL grant DEFAULT_MASTER when no unmasked hbusreq is asserted, even if that master is masked.
REQ-007 SHALL implement a state machine with states DEFAULT, GRANTED, BURST, LOCKED.
- DEFAULT->GRANTED: an unmasked request exists.
- GRANTED->BURST: owner issues NONSEQ with a fixed-length hburst and hready=1.
- GRANTED->LOCKED: the owner's hlock=1.
- BURST->GRANTED: last beat accepted.
- LOCKED->GRANTED: the owner's hlock drops and hready=1 with htrans not SEQ/BUSY.
- Any state->DEFAULT: no unmasked requests when rearbitration is allowed.
REQ-008 SHALL rearbitrate (update hgrant) only in DEFAULT/GRANTED, or in BURST when the beat counter equals 1 and hready=1.
REQ-009 SHALL never rearbitrate in LOCKED.
REQ-010 SHALL load a beat counter on owner NONSEQ&&hready with length-1 (4->3, 8->7, 16->15), decrement it on SEQ&&hready, and hold it on BUSY.
REQ-011 SHALL treat INCR and SINGLE as non-fixed: no burst hold; INCR holds only while hbusreq of the owner stays high.
REQ-012 SHALL update hmaster to the granted index on a clock edge with hready=1, and hold it when hready=0.
REQ-013 SHALL update hmastlock to the granted master's hlock on the same edge as hmaster.
REQ-014 SHALL latch RETRY/SPLIT only in the second response cycle (hresp=10/11 and hready=1).
REQ-015 On SPLIT, SHALL set split-mask bit hmaster, abort any burst/lock hold, and rearbitrate next edge.
REQ-016 On RETRY, SHALL leave the mask unchanged and clear the burst counter.
REQ-017 On ERROR, SHALL leave arbitration state unchanged.
REQ-018 SHALL clear mask bit n on any edge with hsplit[n]=1. If a SPLIT set and an hsplit clear hit the same bit in the same cycle, the clear SHALL win.
REQ-019 SHALL make a master whose mask clears eligible on the following arbitration.

Reset
REQ-020 While hreset=1, SHALL force asynchronously: hgrant one-hot at DEFAULT_MASTER, hmaster=DEFAULT_MASTER, hmastlock=0, state DEFAULT, RR pointer=DEFAULT_MASTER, split mask=0000, beat counter=0.
REQ-021 SHALL discard any burst, lock, or split context on reset mid-operation; the first edge after release SHALL arbitrate normally.

Verification
REQ-022 All four hbusreq high, SINGLE transfers, hready=1 -> grants rotate 1,2,3,4,1 on successive arbitrations; hmaster follows one edge later.
REQ-023 Master 2 INCR8 NONSEQ with master 3 requesting -> hgrant_2 held for 7 SEQ beats; hgrant_3 asserts on the edge that accepts the 8th beat address; hready=0 stalls extend the hold.
REQ-024 Master 1 hlock=1 over 3 transfers with masters 2-4 requesting -> hgrant_1 and hmastlock=1 held throughout; grant moves to master 2 after hlock drops.
REQ-025 Owner master 3 receives SPLIT (two cycles) -> mask=0100, grant moves to the next requester; hsplit=0100 -> master 3 is re-granted in RR order.
REQ-026 No requests -> hgrant at DEFAULT_MASTER. Asserting hreset mid-INCR16 -> outputs return to reset values immediately, mask=0.
